// File: rtl/hlsm_scoreboard.sv
// Self-contained stimulus/compare sequencer: issues LFSR-driven transactions to a DUT and a
// reference model, then checks done timing, latency and per-channel result agreement.
module hlsm_scoreboard #(
    parameter int unsigned          DATAWIDTH = 32,
    parameter int unsigned          NUM_IN    = 3,
    parameter int unsigned          NUM_OUT   = 2,
    parameter logic [NUM_IN-1:0]    BOOL_MASK = 3'b110,
    parameter int unsigned          LATENCY   = 9,
    parameter int unsigned          TIMEOUT   = 64,
    parameter int unsigned          NUM_TRANS = 100,
    parameter logic [31:0]          SEED      = 32'h1
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Enable,
    output logic                           Start,
    output logic [NUM_IN*DATAWIDTH-1:0]    Stim,
    input  logic                           Done,
    input  logic                           DoneRef,
    input  logic [NUM_OUT*DATAWIDTH-1:0]   DutOut,
    input  logic [NUM_OUT*DATAWIDTH-1:0]   RefOut,
    output logic [NUM_OUT-1:0]             ChanErr,
    output logic                           DoneErr,
    output logic                           LatErr,
    output logic                           Timeout,
    output logic                           Err,
    output logic [15:0]                    ErrCount,
    output logic [15:0]                    TransCount,
    output logic                           Finished
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] LatC = CntW'(LATENCY);
    localparam logic [CntW-1:0] ToC  = CntW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StFinish} state_e;

    state_e                        state_q, state_d;
    logic [31:0]                   lfsr_q, lfsr_d;
    logic [NUM_IN*DATAWIDTH-1:0]   stim_q, stim_d;
    logic                          start_q, start_d;
    logic [CntW-1:0]               cnt_q, cnt_d;
    logic [NUM_OUT-1:0]            chan_err_q, chan_err_d;
    logic                          done_err_q, done_err_d;
    logic                          lat_err_q, lat_err_d;
    logic                          timeout_q, timeout_d;
    logic [15:0]                   err_cnt_q, err_cnt_d;
    logic [15:0]                   trans_q, trans_d;

    logic [NUM_OUT-1:0]            chan_mis;
    logic                          lat_bad;
    logic [1:0]                    err_inc;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [NUM_IN*DATAWIDTH-1:0] map_stim(input logic [31:0] v);
        logic [NUM_IN*DATAWIDTH-1:0] s;
        logic [31:0]                 r;
        s = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            r = rotl(v, (7 * i) % 32);
            if (BOOL_MASK[i]) begin
                s[i*DATAWIDTH +: DATAWIDTH] = DATAWIDTH'(r[0]);
            end else begin
                s[i*DATAWIDTH +: DATAWIDTH] = DATAWIDTH'(r);
            end
        end
        return s;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        stim_d     = stim_q;
        start_d    = 1'b0;
        cnt_d      = cnt_q;
        chan_err_d = chan_err_q;
        done_err_d = done_err_q;
        lat_err_d  = lat_err_q;
        timeout_d  = timeout_q;
        err_cnt_d  = err_cnt_q;
        trans_d    = trans_q;
        chan_mis   = '0;
        lat_bad    = 1'b0;
        err_inc    = 2'd0;

        unique case (state_q)
            StIdle: begin
                if (Enable) begin
                    chan_err_d = '0;
                    done_err_d = 1'b0;
                    lat_err_d  = 1'b0;
                    timeout_d  = 1'b0;
                    err_cnt_d  = '0;
                    trans_d    = '0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                // Galois step; Start and Stim become visible together on the following cycle.
                lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
                stim_d  = map_stim(lfsr_d);
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (Done != DoneRef) begin
                    done_err_d = 1'b1;
                    err_inc    = 2'd1;
                end
                if (Done) begin
                    for (int j = 0; j < NUM_OUT; j++) begin
                        chan_mis[j] = DutOut[j*DATAWIDTH +: DATAWIDTH]
                                      != RefOut[j*DATAWIDTH +: DATAWIDTH];
                    end
                    lat_bad    = (cnt_q != LatC);
                    chan_err_d = chan_err_q | chan_mis;
                    if (lat_bad) begin
                        lat_err_d = 1'b1;
                    end
                    if ((|chan_mis) || lat_bad) begin
                        err_inc = err_inc + 2'd1;
                    end
                    trans_d = sat_add(trans_q, 2'd1);
                    if (32'(trans_d) >= NUM_TRANS) begin
                        state_d = StFinish;
                    end else if (Enable) begin
                        state_d = StIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (cnt_q == ToC) begin
                    timeout_d = 1'b1;
                    err_inc   = err_inc + 2'd1;
                    state_d   = StFinish;
                end
                err_cnt_d = sat_add(err_cnt_q, err_inc);
            end
            StFinish: begin
                if (!Enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= StIdle;
            lfsr_q     <= SEED;
            stim_q     <= '0;
            start_q    <= 1'b0;
            cnt_q      <= '0;
            chan_err_q <= '0;
            done_err_q <= 1'b0;
            lat_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            err_cnt_q  <= '0;
            trans_q    <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            stim_q     <= stim_d;
            start_q    <= start_d;
            cnt_q      <= cnt_d;
            chan_err_q <= chan_err_d;
            done_err_q <= done_err_d;
            lat_err_q  <= lat_err_d;
            timeout_q  <= timeout_d;
            err_cnt_q  <= err_cnt_d;
            trans_q    <= trans_d;
        end
    end

    assign Start      = start_q;
    assign Stim       = stim_q;
    assign ChanErr    = chan_err_q;
    assign DoneErr    = done_err_q;
    assign LatErr     = lat_err_q;
    assign Timeout    = timeout_q;
    assign Err        = (|chan_err_q) | done_err_q | lat_err_q | timeout_q;
    assign ErrCount   = err_cnt_q;
    assign TransCount = trans_q;
    assign Finished   = (state_q == StFinish);

endmodule

// File: tb/tb_hlsm_scoreboard.sv
// Directed/randomized bench: plays DUT and reference model around hlsm_scoreboard and checks
// its flags and counters against expectations derived from the transaction rules.
module tb_hlsm_scoreboard;

    localparam int DW  = 32;
    localparam int NI  = 3;
    localparam int NO  = 2;
    localparam int LAT = 9;
    localparam int TO  = 64;
    localparam int NT  = 4;
    localparam logic [2:0]  BM   = 3'b110;
    localparam logic [31:0] SEED = 32'h1;

    logic              Clk = 1'b0;
    logic              Rst, Enable, Done, DoneRef;
    logic [NO*DW-1:0]  DutOut, RefOut;
    logic              Start, DoneErr, LatErr, Timeout, Err, Finished;
    logic [NI*DW-1:0]  Stim;
    logic [NO-1:0]     ChanErr;
    logic [15:0]       ErrCount, TransCount;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          prev_start;
    logic [31:0] m_lfsr;

    hlsm_scoreboard #(
        .DATAWIDTH(DW), .NUM_IN(NI), .NUM_OUT(NO), .BOOL_MASK(BM), .LATENCY(LAT),
        .TIMEOUT(TO), .NUM_TRANS(NT), .SEED(SEED)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Start(Start), .Stim(Stim), .Done(Done),
        .DoneRef(DoneRef), .DutOut(DutOut), .RefOut(RefOut), .ChanErr(ChanErr),
        .DoneErr(DoneErr), .LatErr(LatErr), .Timeout(Timeout), .Err(Err),
        .ErrCount(ErrCount), .TransCount(TransCount), .Finished(Finished)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        if (x[0]) return (x >> 1) ^ 32'h8020_0003;
        return x >> 1;
    endfunction

    function automatic logic [NI*DW-1:0] exp_stim(input logic [31:0] v);
        logic [NI*DW-1:0] s;
        logic [63:0]      d;
        s = '0;
        for (int i = 0; i < NI; i++) begin
            d = {v, v} << ((7 * i) % 32);
            s[i*DW +: DW] = BM[i] ? {31'b0, d[32]} : d[63:32];
        end
        return s;
    endfunction

    // Waits (bounded) for a Start pulse, advances the model LFSR and checks Stim.
    task automatic wait_start(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (Start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        total++;
        assert (seen) else begin
            bad++;
            $error("FAIL %s_start observed=none expected=pulse", tag);
        end
        if (seen) begin
            m_lfsr = lfsr_next(m_lfsr);
            chk({tag, "_stim"}, Stim, exp_stim(m_lfsr));
            prev_start = cyc;
        end
    endtask

    // Called on the Start cycle (cycle 0); drives Done at cycle dl, DoneRef at cycle rl.
    task automatic drive_trans(input int dl, input int rl, input logic [NO-1:0] bump,
                               input int drop_at);
        int last;
        last = (dl > rl) ? dl : rl;
        for (int k = 0; k <= last; k++) begin
            if (k == drop_at) Enable = 1'b0;
            Done    = (k == dl);
            DoneRef = (k == rl);
            RefOut  = {$urandom, $urandom};
            DutOut  = RefOut;
            for (int j = 0; j < NO; j++) begin
                if (bump[j]) DutOut[j*DW +: DW] = RefOut[j*DW +: DW] + 32'd1;
            end
            @(negedge Clk);
        end
        Done    = 1'b0;
        DoneRef = 1'b0;
    endtask

    initial begin
        int gap, nstart, dl, rl, ev, exp_err;
        logic [NO-1:0] bump, exp_chan;
        bit exp_done, exp_lat;

        Rst = 1'b1; Enable = 1'b0; Done = 1'b0; DoneRef = 1'b0;
        DutOut = '0; RefOut = '0; m_lfsr = SEED; prev_start = 0;
        repeat (3) @(negedge Clk);
        chk("rst_start", Start, 0);
        chk("rst_stim", Stim, 0);
        chk("rst_errcnt", ErrCount, 0);
        chk("rst_transcnt", TransCount, 0);
        chk("rst_finished", Finished, 0);
        chk("rst_err", Err, 0);
        chk("rst_chanerr", ChanErr, 0);

        // Ideal run: four transactions back to back.
        Rst = 1'b0; Enable = 1'b1;
        @(negedge Clk);
        chk("first_edge_no_start", Start, 0);
        chk("first_edge_stim_zero", Stim, 0);
        wait_start("a0");
        chk("a0_ch0_const", Stim[31:0], 32'h8020_0003);
        drive_trans(LAT, LAT, '0, -1);
        for (int t = 1; t < NT; t++) begin
            gap = prev_start;
            wait_start("a");
            chk("a_start_gap", prev_start - gap, 11);
            drive_trans(LAT, LAT, '0, -1);
        end
        chk("a_finished", Finished, 1);
        chk("a_transcnt", TransCount, NT);
        chk("a_err", Err, 0);
        chk("a_errcnt", ErrCount, 0);

        // Done in FINISH and in IDLE must be ignored.
        Done = 1'b1; DoneRef = 1'b0; DutOut = ~RefOut;
        @(negedge Clk);
        Done = 1'b0;
        @(negedge Clk);
        chk("fin_done_ignored", DoneErr, 0);
        chk("fin_errcnt_hold", ErrCount, 0);
        chk("fin_no_start", Start, 0);
        Enable = 1'b0;
        @(negedge Clk);
        Done = 1'b1;
        @(negedge Clk);
        Done = 1'b0;
        chk("idle_done_ignored", DoneErr, 0);
        chk("idle_transcnt_hold", TransCount, NT);

        // Early DUT Done: one mismatch event plus one latency failure.
        Enable = 1'b1;
        @(negedge Clk);
        chk("b_cleared", TransCount, 0);
        wait_start("b0");
        drive_trans(LAT - 1, LAT, '0, -1);
        chk("b_doneerr", DoneErr, 1);
        chk("b_laterr", LatErr, 1);
        chk("b_errcnt", ErrCount, 2);
        chk("b_chanerr", ChanErr, 0);
        chk("b_transcnt", TransCount, 1);
        chk("b_err", Err, 1);
        wait_start("b1");
        drive_trans(LAT, LAT, '0, 3);
        nstart = 0;
        for (int n = 0; n < 20; n++) begin
            if (Start === 1'b1) nstart++;
            @(negedge Clk);
        end
        chk("b_no_start_after_drop", nstart, 0);
        chk("b_transcnt2", TransCount, 2);
        chk("b_errcnt_hold", ErrCount, 2);

        // Channel 1 off by one.
        Enable = 1'b1;
        @(negedge Clk);
        chk("c_cleared", ErrCount, 0);
        chk("c_doneerr_cleared", DoneErr, 0);
        wait_start("c0");
        drive_trans(LAT, LAT, 2'b10, 4);
        chk("c_chanerr", ChanErr, 2'b10);
        chk("c_errcnt", ErrCount, 1);
        chk("c_laterr", LatErr, 0);
        chk("c_doneerr", DoneErr, 0);

        // No Done at all: timeout when the counter reaches TIMEOUT.
        Enable = 1'b1;
        @(negedge Clk);
        wait_start("d0");
        repeat (TO) @(negedge Clk);
        chk("d_timeout_not_yet", Timeout, 0);
        @(negedge Clk);
        chk("d_timeout", Timeout, 1);
        chk("d_finished", Finished, 1);
        chk("d_transcnt", TransCount, 0);
        chk("d_errcnt", ErrCount, 1);
        chk("d_err", Err, 1);
        Enable = 1'b0;
        @(negedge Clk);
        chk("d_timeout_held", Timeout, 1);

        // Done exactly at TIMEOUT counts as Done.
        Enable = 1'b1;
        @(negedge Clk);
        wait_start("e0");
        drive_trans(TO, TO, '0, -1);
        chk("e_no_timeout", Timeout, 0);
        chk("e_laterr", LatErr, 1);
        chk("e_transcnt", TransCount, 1);
        chk("e_errcnt", ErrCount, 1);

        // Asynchronous reset in the middle of the next transaction.
        wait_start("e1");
        repeat (4) @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        chk("mid_rst_start", Start, 0);
        chk("mid_rst_stim", Stim, 0);
        chk("mid_rst_transcnt", TransCount, 0);
        chk("mid_rst_laterr", LatErr, 0);
        chk("mid_rst_errcnt", ErrCount, 0);
        m_lfsr = SEED;
        Enable = 1'b0;
        @(negedge Clk);
        Rst = 1'b0; Enable = 1'b1;

        // Randomized run against the rule-level model.
        exp_err = 0; exp_chan = '0; exp_done = 1'b0; exp_lat = 1'b0;
        for (int t = 0; t < NT; t++) begin
            wait_start("f");
            if (t == 0) begin
                chk("f_ch0_post_seed", Stim[31:0], 32'h8020_0003);
                chk("f_ch1_bool", Stim[63:33], 0);
                chk("f_ch2_bool", Stim[95:65], 0);
            end
            dl = ($urandom_range(0, 3) == 0) ? LAT : $urandom_range(0, 20);
            case ($urandom_range(0, 2))
                0:       rl = dl;
                1:       rl = dl + 1;
                default: rl = $urandom_range(0, dl);
            endcase
            bump = 2'($urandom_range(0, 3));
            ev = (rl < dl) ? 2 : ((rl == dl) ? 0 : 1);
            exp_err  += ev + (((bump != 0) || (dl != LAT)) ? 1 : 0);
            exp_chan |= bump;
            exp_done |= (ev != 0);
            exp_lat  |= (dl != LAT);
            drive_trans(dl, rl, bump, -1);
        end
        chk("f_errcnt", ErrCount, exp_err);
        chk("f_chanerr", ChanErr, exp_chan);
        chk("f_doneerr", DoneErr, exp_done);
        chk("f_laterr", LatErr, exp_lat);
        chk("f_transcnt", TransCount, NT);
        chk("f_finished", Finished, 1);
        chk("f_err", Err, (exp_err != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
